sysid_checker: RTL and testbench

- Avalon-MM read master that sits directly upstream of the system-ID slave and consumes its two read-only words: ID at address 0, build timestamp at address 1.
- Reads both words after reset or on request and compares them against the values expected by the software build.
- Drives pass/fail status flags so the HPS bridge and the LEDs can refuse to run on a bitstream/software mismatch.

---
 rtl/sysid_checker.sv | 129 ++++++++++++
 tb/tb_sysid_checker.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/sysid_checker.sv
`timescale 1ns/1ps
// Reads the system-ID slave (ID at word 0, build timestamp at word 1) and flags a bitstream/software mismatch.
// Latency: done 3 cycles after start with a zero-wait slave; each read stalls on avm_waitrequest up to TIMEOUT_CYCLES.
module sysid_checker #(
    parameter logic [31:0] EXPECTED_ID    = 32'hACD51302,
    parameter logic [31:0] EXPECTED_TS    = 32'h52D91E26,
    parameter bit          CHECK_TS       = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter bit          AUTO_START     = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PEND  = 3'd1,
        RD_ID = 3'd2,
        RD_TS = 3'd3,
        FIN   = 3'd4
    } state_t;

    // The abort fires on the edge that ends the TIMEOUT_CYCLES-th stalled cycle,
    // so the counter only has to reach TIMEOUT_CYCLES-1 beforehand.
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic [15:0] wait_cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= AUTO_START ? PEND : IDLE;
            wait_cnt    <= '0;
            avm_address <= 1'b0;
            avm_read    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            id_ok       <= 1'b0;
            ts_ok       <= 1'b0;
            timeout     <= 1'b0;
            id_value    <= '0;
            ts_value    <= '0;
        end else begin
            case (state)
                PEND: begin
                    state       <= RD_ID;
                    wait_cnt    <= '0;
                    avm_address <= 1'b0;
                    avm_read    <= 1'b1;
                    busy        <= 1'b1;
                end
                IDLE, FIN: begin
                    if (start) begin
                        state       <= RD_ID;
                        wait_cnt    <= '0;
                        avm_address <= 1'b0;
                        avm_read    <= 1'b1;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        id_ok       <= 1'b0;
                        ts_ok       <= 1'b0;
                        timeout     <= 1'b0;
                    end
                end
                RD_ID: begin
                    if (!avm_waitrequest) begin
                        state       <= RD_TS;
                        wait_cnt    <= '0;
                        avm_address <= 1'b1;
                        id_value    <= avm_readdata;
                        id_ok       <= (avm_readdata == EXPECTED_ID);
                    end else if (wait_cnt == WAIT_LAST) begin
                        state    <= FIN;
                        wait_cnt <= '0;
                        avm_read <= 1'b0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        timeout  <= 1'b1;
                        id_ok    <= 1'b0;
                        ts_ok    <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                RD_TS: begin
                    if (!avm_waitrequest) begin
                        state    <= FIN;
                        wait_cnt <= '0;
                        avm_read <= 1'b0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        ts_value <= avm_readdata;
                        ts_ok    <= (avm_readdata == EXPECTED_TS) || !CHECK_TS;
                    end else if (wait_cnt == WAIT_LAST) begin
                        // A completed ID read does not count once the TS read times out.
                        state    <= FIN;
                        wait_cnt <= '0;
                        avm_read <= 1'b0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        timeout  <= 1'b1;
                        id_ok    <= 1'b0;
                        ts_ok    <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    avm_read <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sysid_checker.sv
`timescale 1ns/1ps
// Random and directed checks of sysid_checker against a per-check outcome model; dut_a times out at 4, dut_b ignores TS.
module tb_sysid_checker;

    localparam logic [31:0] EID = 32'hACD51302;
    localparam logic [31:0] ETS = 32'h52D91E26;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        rst   [2];
    logic        start [2];
    logic        wr    [2];
    logic [31:0] rdata [2];
    logic        rd    [2];
    logic        addr  [2];
    logic        busy  [2];
    logic        done  [2];
    logic        idok  [2];
    logic        tsok  [2];
    logic        tmo   [2];
    logic [31:0] idv   [2];
    logic [31:0] tsv   [2];

    sysid_checker #(.TIMEOUT_CYCLES(4)) dut_a (
        .clock(clock), .reset(rst[0]), .start(start[0]),
        .avm_address(addr[0]), .avm_read(rd[0]), .avm_waitrequest(wr[0]), .avm_readdata(rdata[0]),
        .busy(busy[0]), .done(done[0]), .id_ok(idok[0]), .ts_ok(tsok[0]), .timeout(tmo[0]),
        .id_value(idv[0]), .ts_value(tsv[0])
    );

    sysid_checker #(.CHECK_TS(1'b0), .AUTO_START(1'b0)) dut_b (
        .clock(clock), .reset(rst[1]), .start(start[1]),
        .avm_address(addr[1]), .avm_read(rd[1]), .avm_waitrequest(wr[1]), .avm_readdata(rdata[1]),
        .busy(busy[1]), .done(done[1]), .id_ok(idok[1]), .ts_ok(tsok[1]), .timeout(tmo[1]),
        .id_value(idv[1]), .ts_value(tsv[1])
    );

    // Slave model configuration and the reference model's view of the captured words.
    int          st_id [2];
    int          st_ts [2];
    logic [31:0] w_id  [2];
    logic [31:0] w_ts  [2];
    logic [31:0] m_idv [2];
    logic [31:0] m_tsv [2];

    int n_checks = 0;
    int n_fail   = 0;

    function automatic int limit_of(input int d);
        return (d == 0) ? 4 : 255;
    endfunction

    function automatic bit check_ts_of(input int d);
        return (d == 0);
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Slave: stalls the first st_* cycles of each read, then returns the configured word.
    initial begin
        int cnt [2];
        logic prd [2];
        logic padr [2];
        for (int d = 0; d < 2; d++) begin
            wr[d] = 1'b0; rdata[d] = '0; cnt[d] = 0; prd[d] = 1'b0; padr[d] = 1'b0;
        end
        forever begin
            @(posedge clock);
            #1;
            for (int d = 0; d < 2; d++) begin
                if (rd[d] === 1'b1 && prd[d] && addr[d] == padr[d]) cnt[d]++;
                else cnt[d] = 0;
                prd[d]   = (rd[d] === 1'b1);
                padr[d]  = addr[d];
                wr[d]    = (rd[d] === 1'b1) && (cnt[d] < (addr[d] ? st_ts[d] : st_id[d]));
                rdata[d] = addr[d] ? w_ts[d] : w_id[d];
            end
        end
    end

    // One full check; called at a negedge. do_start=0 relies on AUTO_START after reset.
    task automatic run_check(input int d, input bit do_start, input bit poke,
                             input logic [31:0] wid, input logic [31:0] wts,
                             input int sid, input int sts);
        int   lim;
        bit   to_id, to_ts, e_tmo, e_idok, e_tsok;
        int   n_id, n_ts;
        logic [31:0] e_idv, e_tsv;
        lim    = limit_of(d);
        to_id  = (sid >= lim);
        to_ts  = !to_id && (sts >= lim);
        n_id   = to_id ? lim : sid + 1;
        n_ts   = to_id ? 0 : (to_ts ? lim : sts + 1);
        e_tmo  = to_id || to_ts;
        e_idok = !e_tmo && (wid == EID);
        e_tsok = !e_tmo && ((wts == ETS) || !check_ts_of(d));
        e_idv  = to_id ? m_idv[d] : wid;
        e_tsv  = e_tmo ? m_tsv[d] : wts;

        w_id[d] = wid; w_ts[d] = wts; st_id[d] = sid; st_ts[d] = sts;
        if (do_start) start[d] = 1'b1;
        for (int c = 1; c <= n_id + n_ts; c++) begin
            @(negedge clock);
            start[d] = poke && (c == 1);
            check("bus", {rd[d], addr[d], busy[d]}, {1'b1, (c > n_id) ? 1'b1 : 1'b0, 1'b1});
            if (c == 1) begin
                check("clear", {done[d], idok[d], tsok[d], tmo[d]}, 4'b0000);
                check("hold_id", idv[d], m_idv[d]);
            end
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clock);
            start[d] = 1'b0;
            check("fin_bus", {rd[d], busy[d], done[d]}, 3'b001);
            check("flags", {idok[d], tsok[d], tmo[d]}, {e_idok, e_tsok, e_tmo});
        end
        check("id_value", idv[d], e_idv);
        check("ts_value", tsv[d], e_tsv);
        m_idv[d] = e_idv;
        m_tsv[d] = e_tsv;
    endtask

    task automatic check_idle(input int d, input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clock);
            check("idle", {rd[d], busy[d], done[d]}, 3'b000);
        end
    endtask

    // Asynchronous reset landing in the middle of the TS read.
    task automatic reset_mid(input int d);
        w_id[d] = EID; w_ts[d] = ETS; st_id[d] = 0; st_ts[d] = 3;
        start[d] = 1'b1;
        @(negedge clock);
        start[d] = 1'b0;
        @(negedge clock);
        check("pre_rst_ts", {rd[d], addr[d]}, 2'b11);
        #2 rst[d] = 1'b1;
        #1;
        check("rst_async", {rd[d], addr[d], busy[d], done[d], idok[d], tsok[d], tmo[d]}, 7'd0);
        check("rst_idv", idv[d], 32'd0);
        @(negedge clock);
        rst[d] = 1'b0;
        m_idv[d] = '0;
        m_tsv[d] = '0;
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; start[d] = 1'b0;
            st_id[d] = 0; st_ts[d] = 0; w_id[d] = EID; w_ts[d] = ETS;
            m_idv[d] = '0; m_tsv[d] = '0;
        end
        #12;
        for (int d = 0; d < 2; d++) begin
            check("reset_flags", {rd[d], addr[d], busy[d], done[d], idok[d], tsok[d], tmo[d]}, 7'd0);
            check("reset_vals", {idv[d], tsv[d]}, 64'd0);
        end
        @(negedge clock);
        rst[0] = 1'b0; rst[1] = 1'b0;

        run_check(0, 1'b0, 1'b0, EID, ETS, 0, 0);
        check_idle(1, 2);

        run_check(0, 1'b1, 1'b0, 32'hDEADBEEF, ETS, 0, 0);
        run_check(0, 1'b1, 1'b0, EID, 32'h00000001, 0, 0);
        run_check(1, 1'b1, 1'b0, EID, 32'h00000001, 0, 0);
        run_check(1, 1'b1, 1'b0, EID, ETS, 3, 3);
        run_check(0, 1'b1, 1'b0, EID, ETS, 0, 100);
        run_check(0, 1'b1, 1'b0, EID, ETS, 0, 0);
        run_check(0, 1'b1, 1'b1, EID, ETS, 1, 1);
        run_check(0, 1'b1, 1'b0, EID, ETS, 3, 3);
        run_check(0, 1'b1, 1'b0, 32'h12345678, ETS, 4, 0);

        for (int i = 0; i < 40; i++) begin
            int d;
            logic [31:0] wid, wts;
            d   = int'($urandom_range(0, 1));
            wid = ($urandom_range(0, 1) == 0) ? EID : $urandom;
            wts = ($urandom_range(0, 1) == 0) ? ETS : $urandom;
            run_check(d, 1'b1, ($urandom_range(0, 3) == 0),
                      wid, wts, int'($urandom_range(0, 6)), int'($urandom_range(0, 6)));
        end

        reset_mid(0);
        run_check(0, 1'b0, 1'b0, EID, ETS, 0, 0);
        reset_mid(1);
        check_idle(1, 3);
        run_check(1, 1'b1, 1'b0, EID, 32'hCAFEF00D, 2, 1);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
